// File: rtl/vp_recovery_pkg.sv
// Shared types and constants for the load-value-prediction recovery controller.
package vp_recovery_pkg;

  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned STAT_WIDTH     = 32;

  localparam logic [ADDR_WIDTH-1:0] REDIRECT_OFFSET = ADDR_WIDTH'(4);

  typedef enum logic [2:0] {
    IDLE,
    SPEC,
    FLUSH,
    ROLLBACK,
    REDIRECT,
    HS,
    RELEASE
  } vp_rec_state_t;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     data;
  } undo_entry_t;

endpackage

// File: rtl/vp_undo_stack.sv
// LIFO undo log of {register, overwritten value}; clear beats pop beats push.
module vp_undo_stack
  import vp_recovery_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    push,
  input  logic                    pop,
  input  undo_entry_t             push_entry,
  output undo_entry_t             top_c,
  output logic                    full_c,
  output logic                    empty_c,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  undo_entry_t   mem_q [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] top_idx;
  logic          do_push;

  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == '0);
  assign do_push = push && !full_c && !pop && !clear;
  assign top_idx = PW'(count_q - CW'(1));
  assign top_c   = mem_q[top_idx];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (clear)               count_d = '0;
    else if (pop && !empty_c) count_d = count_q - CW'(1);
    else if (do_push)        count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // Storage needs no reset: entries above the count are never read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[PW'(count_q)] <= push_entry;
  end

endmodule

// File: rtl/vp_recovery_ctrl.sv
// Value-prediction misprediction recovery: undo-log, rollback, redirect, handshake.
// Define VP_RECOVERY_STATS_EN to build the recovery/commit event counters.
module vp_recovery_ctrl
  import vp_recovery_pkg::*;
#(
  parameter int unsigned LOG_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      spec_start,
  input  logic [ADDR_WIDTH-1:0]     spec_pc,
  input  logic                      vp_done,
  input  logic                      en_recover,
  input  logic                      recovery_done_ack,
  input  logic                      rf_wr_valid,
  input  logic [REG_ADDR_WIDTH-1:0] rf_wr_addr,
  input  logic [DATA_WIDTH-1:0]     rf_old_data,
  output logic                      flush,
  output logic                      rb_wr_valid,
  output logic [REG_ADDR_WIDTH-1:0] rb_wr_addr,
  output logic [DATA_WIDTH-1:0]     rb_wr_data,
  output logic                      redirect_valid,
  output logic [ADDR_WIDTH-1:0]     redirect_pc,
  output logic                      recovery_done,
  output logic                      out_lock_off,
  output logic                      spec_stall,
  output logic [STAT_WIDTH-1:0]     stat_recoveries,
  output logic [STAT_WIDTH-1:0]     stat_commits
);

  localparam int unsigned CW = $clog2(LOG_DEPTH) + 1;

  vp_rec_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0]     pc_q, pc_d;
  logic                      flush_q, flush_d;
  logic                      rb_valid_q, rb_valid_d;
  logic [REG_ADDR_WIDTH-1:0] rb_addr_q, rb_addr_d;
  logic [DATA_WIDTH-1:0]     rb_data_q, rb_data_d;
  logic                      redir_valid_q, redir_valid_d;
  logic [ADDR_WIDTH-1:0]     redir_pc_q, redir_pc_d;
  logic                      done_q, done_d;
  logic                      lock_off_q, lock_off_d;

  logic                      clear_c, push_c, pop_c, full_c, empty_c;
  logic [CW-1:0]             log_count;
  undo_entry_t               push_entry_c, top_c;

  assign push_entry_c = '{rd: rf_wr_addr, data: rf_old_data};

  vp_undo_stack #(.DEPTH(LOG_DEPTH)) u_log (
    .clk        (clk),
    .rst        (rst_n),
    .clear      (clear_c),
    .push       (push_c),
    .pop        (pop_c),
    .push_entry (push_entry_c),
    .top_c      (top_c),
    .full_c     (full_c),
    .empty_c    (empty_c),
    .count      (log_count)
  );

  // Outputs are registered decodes of the next state, so each appears in the state's own cycle.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    clear_c       = 1'b0;
    push_c        = 1'b0;
    pop_c         = 1'b0;

    case (state_q)
      IDLE: begin
        if (spec_start) begin
          pc_d    = spec_pc;
          clear_c = 1'b1;
          state_d = SPEC;
        end
      end
      SPEC: begin
        push_c = rf_wr_valid && (rf_wr_addr != '0) && !full_c;
        if (en_recover) begin
          state_d = FLUSH;
        end else if (vp_done) begin
          clear_c = 1'b1;
          state_d = IDLE;
        end
      end
      FLUSH, ROLLBACK: begin
        if (empty_c) begin
          state_d = REDIRECT;
        end else begin
          pop_c   = 1'b1;
          state_d = ROLLBACK;
        end
      end
      REDIRECT: state_d = HS;
      HS:       if (recovery_done_ack) state_d = RELEASE;
      RELEASE:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    flush_d       = (state_d == FLUSH);
    rb_valid_d    = pop_c;
    rb_addr_d     = pop_c ? top_c.rd : '0;
    rb_data_d     = pop_c ? top_c.data : '0;
    redir_valid_d = (state_d == REDIRECT);
    redir_pc_d    = (state_d == REDIRECT) ? pc_q + REDIRECT_OFFSET : '0;
    done_d        = (state_d == HS);
    lock_off_d    = (state_d == RELEASE);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      flush_q       <= 1'b0;
      rb_valid_q    <= 1'b0;
      rb_addr_q     <= '0;
      rb_data_q     <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      done_q        <= 1'b0;
      lock_off_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      flush_q       <= flush_d;
      rb_valid_q    <= rb_valid_d;
      rb_addr_q     <= rb_addr_d;
      rb_data_q     <= rb_data_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      done_q        <= done_d;
      lock_off_q    <= lock_off_d;
    end
  end

  assign flush          = flush_q;
  assign rb_wr_valid    = rb_valid_q;
  assign rb_wr_addr     = rb_addr_q;
  assign rb_wr_data     = rb_data_q;
  assign redirect_valid = redir_valid_q;
  assign redirect_pc    = redir_pc_q;
  assign recovery_done  = done_q;
  assign out_lock_off   = lock_off_q;
  assign spec_stall     = (state_q == SPEC) && (log_count == CW'(LOG_DEPTH));

`ifdef VP_RECOVERY_STATS_EN
  logic [STAT_WIDTH-1:0] rec_q, rec_d, com_q, com_d;

  always_comb begin
    rec_d = rec_q + STAT_WIDTH'(state_q == REDIRECT);
    com_d = com_q + STAT_WIDTH'((state_q == SPEC) && vp_done && !en_recover);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      rec_q <= '0;
      com_q <= '0;
    end else begin
      rec_q <= rec_d;
      com_q <= com_d;
    end
  end

  assign stat_recoveries = rec_q;
  assign stat_commits    = com_q;
`else
  assign stat_recoveries = '0;
  assign stat_commits    = '0;
`endif

endmodule

// File: tb/tb_vp_recovery_ctrl.sv
// Self-checking bench for vp_recovery_ctrl: directed plan scenarios plus random traffic vs a timeline model.
module tb_vp_recovery_ctrl;
  import vp_recovery_pkg::*;

  localparam int unsigned DEPTH = 8;
`ifdef VP_RECOVERY_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      spec_start;
  logic [ADDR_WIDTH-1:0]     spec_pc;
  logic                      vp_done, en_recover, recovery_done_ack;
  logic                      rf_wr_valid;
  logic [REG_ADDR_WIDTH-1:0] rf_wr_addr;
  logic [DATA_WIDTH-1:0]     rf_old_data;
  logic                      flush, rb_wr_valid, redirect_valid, recovery_done, out_lock_off, spec_stall;
  logic [REG_ADDR_WIDTH-1:0] rb_wr_addr;
  logic [DATA_WIDTH-1:0]     rb_wr_data;
  logic [ADDR_WIDTH-1:0]     redirect_pc;
  logic [31:0]               stat_recoveries, stat_commits;

  always #5 clk = ~clk;

  vp_recovery_ctrl #(.LOG_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .spec_start(spec_start), .spec_pc(spec_pc),
    .vp_done(vp_done), .en_recover(en_recover), .recovery_done_ack(recovery_done_ack),
    .rf_wr_valid(rf_wr_valid), .rf_wr_addr(rf_wr_addr), .rf_old_data(rf_old_data),
    .flush(flush), .rb_wr_valid(rb_wr_valid), .rb_wr_addr(rb_wr_addr), .rb_wr_data(rb_wr_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .recovery_done(recovery_done),
    .out_lock_off(out_lock_off), .spec_stall(spec_stall),
    .stat_recoveries(stat_recoveries), .stat_commits(stat_commits)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a log queue while speculating, and on recovery a precomputed per-cycle output timeline.
  localparam int M_IDLE = 0, M_SPEC = 1, M_RECOV = 2, M_HS = 3, M_REL = 4;

  typedef struct packed {
    logic                      flush;
    logic                      rbv;
    logic [REG_ADDR_WIDTH-1:0] rba;
    logic [DATA_WIDTH-1:0]     rbd;
    logic                      rdv;
    logic [ADDR_WIDTH-1:0]     rdpc;
    logic                      done;
    logic                      lock;
  } exp_t;

  int                    mode = M_IDLE;
  undo_entry_t           mlog[$];
  exp_t                  plan[$];
  exp_t                  cur;
  logic [ADDR_WIDTH-1:0] mpc;
  logic [31:0]           m_rec, m_com;

  task automatic model_step();
    exp_t e;
    undo_entry_t u;
    if (rst_n) begin
      mode = M_IDLE; mlog.delete(); plan.delete(); cur = '0; m_rec = 0; m_com = 0; mpc = '0;
      return;
    end
    cur = '0;
    case (mode)
      M_IDLE: if (spec_start) begin mpc = spec_pc; mlog.delete(); mode = M_SPEC; end
      M_SPEC: begin
        if (rf_wr_valid && rf_wr_addr != 0 && mlog.size() < DEPTH) begin
          u.rd = rf_wr_addr; u.data = rf_old_data; mlog.push_back(u);
        end
        if (en_recover) begin
          e = '0; e.flush = 1'b1; plan.push_back(e);
          while (mlog.size() > 0) begin
            u = mlog.pop_back();
            e = '0; e.rbv = 1'b1; e.rba = u.rd; e.rbd = u.data; plan.push_back(e);
          end
          e = '0; e.rdv = 1'b1; e.rdpc = mpc + 32'd4; plan.push_back(e);
          cur = plan.pop_front();
          mode = M_RECOV;
        end else if (vp_done) begin
          mlog.delete(); m_com++; mode = M_IDLE;
        end
      end
      M_RECOV: begin
        if (plan.size() > 0) cur = plan.pop_front();
        else begin m_rec++; mode = M_HS; cur.done = 1'b1; end
      end
      M_HS: begin
        if (recovery_done_ack) begin mode = M_REL; cur.lock = 1'b1; end
        else cur.done = 1'b1;
      end
      default: mode = M_IDLE;
    endcase
  endtask

  task automatic compare();
    chk("flush", flush, cur.flush);
    chk("rb_wr_valid", rb_wr_valid, cur.rbv);
    if (cur.rbv) begin
      chk("rb_wr_addr", rb_wr_addr, cur.rba);
      chk("rb_wr_data", rb_wr_data, cur.rbd);
    end
    chk("redirect_valid", redirect_valid, cur.rdv);
    if (cur.rdv) chk("redirect_pc", redirect_pc, cur.rdpc);
    chk("recovery_done", recovery_done, cur.done);
    chk("out_lock_off", out_lock_off, cur.lock);
    chk("spec_stall", spec_stall, (mode == M_SPEC) && (mlog.size() == DEPTH));
    chk("stat_recoveries", stat_recoveries, STATS ? m_rec : 32'd0);
    chk("stat_commits", stat_commits, STATS ? m_com : 32'd0);
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    compare();
  end

  task automatic quiet();
    spec_start = 0; spec_pc = '0; vp_done = 0; en_recover = 0; recovery_done_ack = 0;
    rf_wr_valid = 0; rf_wr_addr = '0; rf_old_data = '0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    rf_wr_valid = 1; rf_wr_addr = 5'(a); rf_old_data = d;
  endtask

  task automatic start(input logic [31:0] pc);
    quiet(); spec_start = 1; spec_pc = pc; @(negedge clk); quiet();
  endtask

  task automatic rand_phase(input int cycles, input int rate);
    for (int i = 0; i < cycles; i++) begin
      rst_n             = ($urandom_range(0, 199) == 0);
      spec_start        = ($urandom_range(0, 3) == 0);
      spec_pc           = $urandom;
      rf_wr_valid       = 1'($urandom_range(0, 1));
      rf_wr_addr        = 5'($urandom_range(0, 31));
      rf_old_data       = $urandom;
      vp_done           = ($urandom_range(0, rate - 1) == 0);
      en_recover        = ($urandom_range(0, rate - 1) == 0);
      recovery_done_ack = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
  endtask

  initial begin
    int npop;
    rst_n = 1; quiet();
    repeat (2) @(negedge clk);
    chk("rst_flush", flush, 0);
    chk("rst_done", recovery_done, 0);
    chk("rst_redirect", redirect_valid, 0);
    rst_n = 0;
    @(negedge clk);

    // Correct prediction
    start(32'h40);
    wr(1, 32'hA1); @(negedge clk);
    wr(2, 32'hA2); @(negedge clk);
    wr(7, 32'hA7); @(negedge clk);
    quiet(); vp_done = 1; @(negedge clk); quiet();
    chk("t1_flush", flush, 0);
    chk("t1_stall", spec_stall, 0);
    chk("t1_commits", stat_commits, STATS ? 32'd1 : 32'd0);

    // Misprediction with a two-entry log
    start(32'h40);
    wr(3, 32'h11); @(negedge clk);
    wr(5, 32'h22); @(negedge clk);
    wr(0, 32'h33); @(negedge clk);
    quiet(); en_recover = 1; @(negedge clk); quiet();
    chk("t2_flush", flush, 1);
    @(negedge clk);
    chk("t2_rb1_valid", rb_wr_valid, 1); chk("t2_rb1_addr", rb_wr_addr, 5);
    chk("t2_rb1_data", rb_wr_data, 32'h22);
    @(negedge clk);
    chk("t2_rb2_addr", rb_wr_addr, 3); chk("t2_rb2_data", rb_wr_data, 32'h11);
    @(negedge clk);
    chk("t2_redirect", redirect_valid, 1); chk("t2_redirect_pc", redirect_pc, 32'h44);
    chk("t2_rb_off", rb_wr_valid, 0);
    @(negedge clk);
    chk("t2_done", recovery_done, 1);
    repeat (2) @(negedge clk);
    chk("t2_done_held", recovery_done, 1);
    recovery_done_ack = 1; @(negedge clk); recovery_done_ack = 0;
    chk("t2_lock", out_lock_off, 1); chk("t2_done_drop", recovery_done, 0);
    @(negedge clk);
    chk("t2_lock_pulse", out_lock_off, 0);

    // Empty-log recovery
    start(32'h200);
    en_recover = 1; @(negedge clk); quiet();
    chk("t3_flush", flush, 1);
    @(negedge clk);
    chk("t3_redirect", redirect_valid, 1); chk("t3_redirect_pc", redirect_pc, 32'h204);
    @(negedge clk);
    chk("t3_done", recovery_done, 1);
    recovery_done_ack = 1; @(negedge clk); recovery_done_ack = 0;
    chk("t3_lock", out_lock_off, 1);
    @(negedge clk);

    // Full log: ninth write dropped, exactly eight pops
    start(32'h300);
    for (int i = 1; i <= 9; i++) begin
      wr(i, 32'h100 + i); @(negedge clk);
      if (i == 7) chk("t4_stall_7", spec_stall, 0);
      if (i == 8) chk("t4_stall_8", spec_stall, 1);
    end
    chk("t4_stall_9", spec_stall, 1);
    quiet(); en_recover = 1; @(negedge clk); quiet();
    recovery_done_ack = 1;
    npop = 0;
    repeat (14) begin
      if (rb_wr_valid) npop++;
      @(negedge clk);
    end
    recovery_done_ack = 0;
    chk("t4_pops", npop, 8);

    // en_recover and vp_done together: recovery wins
    start(32'h400);
    wr(4, 32'h44); en_recover = 1; vp_done = 1; @(negedge clk); quiet();
    chk("t5_flush", flush, 1);
    chk("t5_commits", stat_commits, STATS ? 32'd1 : 32'd0);
    recovery_done_ack = 1; repeat (6) @(negedge clk); recovery_done_ack = 0;
    chk("t5_recoveries", stat_recoveries, STATS ? 32'd4 : 32'd0);

    // Reset after the first of four rollback writes
    start(32'h500);
    for (int i = 10; i < 14; i++) begin wr(i, 32'hB0 + i); @(negedge clk); end
    quiet(); en_recover = 1; @(negedge clk); quiet();
    @(negedge clk);
    chk("t6_first_pop", rb_wr_addr, 13);
    rst_n = 1; @(negedge clk); rst_n = 0;
    chk("t6_rb", rb_wr_valid, 0); chk("t6_flush", flush, 0);
    chk("t6_redirect", redirect_valid, 0); chk("t6_done", recovery_done, 0);
    chk("t6_lock", out_lock_off, 0); chk("t6_recs", stat_recoveries, 0);
    repeat (3) @(negedge clk);
    chk("t6_no_rb", rb_wr_valid, 0);
    start(32'h600);
    wr(2, 32'h22); @(negedge clk);
    quiet(); vp_done = 1; @(negedge clk); quiet();
    chk("t6_commits", stat_commits, STATS ? 32'd1 : 32'd0);

    // Random traffic, then slower verdicts so the log fills more often
    rand_phase(3000, 12);
    rand_phase(3000, 40);
    quiet(); rst_n = 0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vp_recovery_ctrl.md
# vp_recovery_ctrl

Misprediction recovery responder for the load value predictor. While a predicted load is outstanding it logs every speculative register-file write with the overwritten value. On `en_recover` it flushes the pipeline, rolls the log back newest-first through a dedicated register-file write port, and redirects fetch to the instruction after the load. It then completes the `recovery_done` / `recovery_done_ack` / `out_lock_off` handshake with the predictor. It sits beside `value_prediction` in `mips_core`, between the predictor, the register file and the fetch redirect mux.

## Interface
Parameters:
- `LOG_DEPTH`, 8: undo-log entries; must be a power of two, at least 2.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-high. Asserting 1 resets the block.
- `spec_start` in 1: the predictor issued a first prediction this cycle.
- `spec_pc` in `ADDR_WIDTH`: PC of the predicted load.
- `vp_done` in 1: the prediction was verified correct.
- `en_recover` in 1: the prediction was verified wrong.
- `recovery_done_ack` in 1: the predictor accepted `recovery_done`.
- `rf_wr_valid` in 1: the register file commits a write this cycle.
- `rf_wr_addr` in 5: destination register of that write.
- `rf_old_data` in `DATA_WIDTH`: value the write overwrites.
- `flush` out 1: kill all in-flight instructions younger than the load.
- `rb_wr_valid`, `rb_wr_addr` (5), `rb_wr_data` (`DATA_WIDTH`) out: rollback write port.
- `redirect_valid` out 1, `redirect_pc` out `ADDR_WIDTH`: fetch redirect.
- `recovery_done` out 1: rollback and redirect are finished.
- `out_lock_off` out 1: release the predictor's output lock.
- `spec_stall` out 1: the log is full; upstream must hold further writes.
- `stat_recoveries`, `stat_commits` out 32 each: event counters.

## Operation
- The block uses an FSM with states IDLE, SPEC, FLUSH, ROLLBACK, REDIRECT, HS, RELEASE.
- IDLE:
  - `spec_start`=1 latches `spec_pc`, empties the log and moves to SPEC.
  - Writes in IDLE are not logged.
- SPEC:
  - `rf_wr_valid` with `rf_wr_addr`≠0 and log not full pushes {addr, old data}.
  - Writes to register 0 are never logged.
  - `vp_done` discards the log, increments `stat_commits` and returns to IDLE.
  - `en_recover` moves to FLUSH.
  - If `en_recover` and `vp_done` are high in the same cycle, `en_recover` wins.
  - A write in the same cycle as `en_recover` is still logged.
- FLUSH: `flush`=1 for exactly one cycle, then ROLLBACK; if the log is empty, go directly to REDIRECT.
- ROLLBACK:
  - One pop per cycle, LIFO, driving `rb_wr_valid`=1 with the popped register and old value.
  - After the last pop, go to REDIRECT.
  - `rf_wr_valid` is ignored (the pipeline is flushed).
- REDIRECT:
  - `redirect_valid`=1 for one cycle with `redirect_pc` = latched `spec_pc` + 4, modulo 2^`ADDR_WIDTH`.
  - Increments `stat_recoveries`, then goes to HS.
- HS: `recovery_done`=1 is held until a cycle with `recovery_done_ack`=1, then RELEASE.
- RELEASE: `out_lock_off`=1 for exactly one cycle, then IDLE.
- `spec_start` is ignored outside IDLE.
- `spec_stall` = (count == `LOG_DEPTH`) in SPEC, 0 otherwise.
- A write presented while the log is full is dropped and the count does not change.
- The log count is a `$clog2(LOG_DEPTH)+1`-bit counter and never wraps.

## Timing
- Reset value of every output is 0; the FSM resets to IDLE, the log count to 0, and the counters to 0.
- Reset mid-recovery aborts immediately: no further rollback writes and no handshake.
- All outputs are registered, except `spec_stall`, which is combinational from the count and state.
- `en_recover` high at edge T with N logged entries gives:
  - `flush` at T+1;
  - rollback writes at T+2 … T+1+N;
  - `redirect_valid` at T+2+N;
  - `recovery_done` from T+3+N until one cycle after the ack edge;
  - `out_lock_off` in the cycle after that.
- Recovery latency is N+3 cycles to `recovery_done`.
- `vp_done` returns the block to IDLE in 1 cycle.
- `spec_start` in IDLE makes SPEC active on the next edge; a write in that same cycle is not logged.

## Configuration
- `VP_RECOVERY_STATS_EN` defined: `stat_recoveries` and `stat_commits` count as described and wrap at 2^32.
- `VP_RECOVERY_STATS_EN` undefined: the counters are not built and both outputs are tied to 0.
- Recovery behaviour is identical in both builds.

## Structure
- Shared package `vp_recovery_pkg`:
  - state enum `vp_rec_state_t`;
  - struct `undo_entry_t` {5-bit reg, `DATA_WIDTH` data};
  - constant `REDIRECT_OFFSET` = 4.
- One sub-module, `vp_undo_stack`, a parameterised LIFO with push, pop, clear, full, empty and count. The FSM lives in the top.

## Test plan
- Correct prediction: `spec_start` at PC 0x0040, 3 writes, then `vp_done` → no `flush`, no `rb_wr_valid`, `stat_commits`=1, IDLE next cycle.
- Misprediction with log: writes r3←old 0x11, r5←old 0x22, r0 (ignored), then `en_recover` → `flush` 1 cycle; rollback r5/0x22 then r3/0x11; `redirect_pc`=0x0044; `recovery_done` held until ack; `out_lock_off` single pulse.
- Empty log: `en_recover` with no logged writes → `flush`, then `redirect` on the next cycle; `recovery_done` at T+3.
- Full log, `LOG_DEPTH`=8: 9 writes → `spec_stall`=1 after the 8th, 9th dropped, recovery pops exactly 8.
- Simultaneous: `en_recover` and `vp_done` in the same cycle → recovery path taken, `stat_commits` unchanged.
- Reset during ROLLBACK after 1 of 4 pops → next cycle all outputs 0, IDLE; later `spec_start` works normally.
